// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared ALU opcode and arbiter state types
package alu_ctrl_pkg;

    localparam int ALU_OP_W = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_SLT = 3'd4
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Opcodes 5..7 have no ALU select and are reported as illegal.
    function automatic logic op_is_legal(input logic [ALU_OP_W-1:0] op);
        return op <= ALU_OP_W'(OP_SLT);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - one-hot grant selector; round-robin when ALU_ARB_ROUND_ROBIN_EN is defined, fixed priority otherwise
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_idx_o
);

    logic [ID_W-1:0] cand;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    // Walk from the farthest candidate to the nearest so the one right after the pointer wins.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        cand      = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = ID_W'((int'(ptr_i) + i) % NUM_REQ);
            if (req_i[cand]) begin
                gnt_o       = '0;
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = cand;
            end
        end
        if (!en_i) begin
            gnt_o     = '0;
            gnt_idx_o = '0;
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    // Walk from the highest index down so the lowest valid index wins.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        cand      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = ID_W'(i);
            if (req_i[cand]) begin
                gnt_o       = '0;
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = cand;
            end
        end
        if (!en_i) begin
            gnt_o     = '0;
            gnt_idx_o = '0;
        end
    end
`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one combinational ALU among requesters; ALU_ARB_ROUND_ROBIN_EN selects round-robin arbitration
module alu_share_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*ALU_OP_W-1:0] req_op,
    input  logic [NUM_REQ*WIDTH-1:0]    req_a,
    input  logic [NUM_REQ*WIDTH-1:0]    req_b,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [ID_W-1:0]             rsp_id,
    output logic [WIDTH-1:0]            rsp_result,
    output logic                        rsp_zero,
    output logic                        rsp_illegal,
    output logic [WIDTH-1:0]            alu_operand_a,
    output logic [WIDTH-1:0]            alu_operand_b,
    output logic                        alu_sel_add,
    output logic                        alu_sel_sub,
    output logic                        alu_sel_and,
    output logic                        alu_sel_or,
    output logic                        alu_sel_slt,
    input  logic [WIDTH-1:0]            alu_result,
    input  logic                        alu_zero_flag
);

    arb_state_e            state_q, state_d;
    logic [ALU_OP_W-1:0]   op_q;
    logic [WIDTH-1:0]      a_q, b_q;
    logic [ID_W-1:0]       id_q;
    logic [WIDTH-1:0]      result_q;
    logic                  zero_q;
    logic                  illegal_q;
    logic [NUM_REQ-1:0]    gnt;
    logic [ID_W-1:0]       gnt_idx;
    logic [ID_W-1:0]       arb_ptr;
    logic                  arb_en;
    logic                  accept;
    logic                  op_legal;

    // Grants only in IDLE and never while reset is asserted.
    assign arb_en    = (state_q == IDLE) && rst_n;
    assign accept    = |gnt;
    assign req_ready = gnt;
    assign op_legal  = op_is_legal(op_q);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i     (req_valid),
        .en_i      (arb_en),
        .ptr_i     (arb_ptr),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] ptr_q;
    assign arb_ptr = ptr_q;

    // Remember the last winner so the search starts just past it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= ID_W'(NUM_REQ - 1);
        end else if (accept) begin
            ptr_q <= gnt_idx;
        end
    end
`else
    assign arb_ptr = ID_W'(NUM_REQ - 1);
`endif

    // Next-state logic and the op-to-select decode, active only in EXEC.
    always_comb begin
        state_d     = state_q;
        alu_sel_add = 1'b0;
        alu_sel_sub = 1'b0;
        alu_sel_and = 1'b0;
        alu_sel_or  = 1'b0;
        alu_sel_slt = 1'b0;
        case (state_q)
            IDLE: if (accept) state_d = EXEC;
            EXEC: begin
                state_d = RESP;
                case (op_q)
                    OP_ADD:  alu_sel_add = 1'b1;
                    OP_SUB:  alu_sel_sub = 1'b1;
                    OP_AND:  alu_sel_and = 1'b1;
                    OP_OR:   alu_sel_or  = 1'b1;
                    OP_SLT:  alu_sel_slt = 1'b1;
                    default: ;
                endcase
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, request latch on grant, and response capture at the end of EXEC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q <= req_op[ALU_OP_W*int'(gnt_idx) +: ALU_OP_W];
                a_q  <= req_a[WIDTH*int'(gnt_idx) +: WIDTH];
                b_q  <= req_b[WIDTH*int'(gnt_idx) +: WIDTH];
                id_q <= gnt_idx;
            end
            if (state_q == EXEC) begin
                result_q  <= op_legal ? alu_result : '0;
                zero_q    <= op_legal ? alu_zero_flag : 1'b1;
                illegal_q <= !op_legal;
            end
        end
    end

    assign rsp_valid     = (state_q == RESP);
    assign rsp_id        = id_q;
    assign rsp_result    = result_q;
    assign rsp_zero      = zero_q;
    assign rsp_illegal   = illegal_q;
    assign alu_operand_a = a_q;
    assign alu_operand_b = b_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for alu_share_arbiter
module tb_alu_share_arbiter;
    import alu_ctrl_pkg::*;

    localparam int WIDTH   = 32;
    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*ALU_OP_W-1:0] req_op;
    logic [NUM_REQ*WIDTH-1:0]    req_a, req_b;
    logic                        rsp_valid, rsp_ready;
    logic [ID_W-1:0]             rsp_id;
    logic [WIDTH-1:0]            rsp_result;
    logic                        rsp_zero, rsp_illegal;
    logic [WIDTH-1:0]            alu_operand_a, alu_operand_b;
    logic                        alu_sel_add, alu_sel_sub, alu_sel_and, alu_sel_or, alu_sel_slt;
    logic [WIDTH-1:0]            alu_result;
    logic                        alu_zero_flag;
    logic [4:0]                  sels;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal),
        .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
        .alu_sel_add(alu_sel_add), .alu_sel_sub(alu_sel_sub), .alu_sel_and(alu_sel_and),
        .alu_sel_or(alu_sel_or), .alu_sel_slt(alu_sel_slt),
        .alu_result(alu_result), .alu_zero_flag(alu_zero_flag)
    );

    assign sels = {alu_sel_add, alu_sel_sub, alu_sel_and, alu_sel_or, alu_sel_slt};

    // Reference ALU driven by the one-hot selects
    always_comb begin
        alu_result = '0;
        if (alu_sel_add) alu_result = alu_operand_a + alu_operand_b;
        if (alu_sel_sub) alu_result = alu_operand_a - alu_operand_b;
        if (alu_sel_and) alu_result = alu_operand_a & alu_operand_b;
        if (alu_sel_or)  alu_result = alu_operand_a | alu_operand_b;
        if (alu_sel_slt) alu_result = WIDTH'(alu_operand_a < alu_operand_b);
    end
    assign alu_zero_flag = (alu_result == '0);

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             illegal;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: structural invariants every cycle, response compare on each handshake
    always @(negedge clk) begin
        if (rst_n) begin
            chk("req_ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
            chk("sel_onehot0", 64'($onehot0(sels)), 64'd1);
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rsp: got id %0d result 0x%0h with no expectation queued", rsp_id, rsp_result);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rsp_id", rsp_id, mon_e.id);
                    chk("rsp_result", rsp_result, mon_e.result);
                    chk("rsp_zero", rsp_zero, mon_e.zero);
                    chk("rsp_illegal", rsp_illegal, mon_e.illegal);
                end
            end
        end
    end

    // Raise one request, wait (bounded) for its grant, queue its expectation, drop it after acceptance
    task automatic send(input int id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ez, input logic eil, input bit push,
                        output int waited);
        req_op[3*id +: 3]  = op;
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        req_valid[id]      = 1'b1;
        waited = 0;
        #1;
        while (!req_ready[id] && waited < 30) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("grant_wait_bounded", 64'(waited < 30), 64'd1);
        if (push) sb.push_back('{id: ID_W'(id), result: er, zero: ez, illegal: eil});
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    int          w;
    int          g;
    int          n;
    int          exp_ids[4];
    logic [31:0] snap_r;
    logic        snap_z;
    logic [ID_W-1:0] snap_id;

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        req_valid[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_result", rsp_result, 0);
        chk("reset_operand_a", alu_operand_a, 0);
        chk("reset_sels", sels, 0);
        req_valid = '0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single ADD with latency checks
        send(0, 3'd0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1'b1, w);
        chk("add_same_cycle_ready", w, 0);
        chk("add_exec_rsp_valid", rsp_valid, 0);
        chk("add_exec_sel", sels, 5'b10000);
        chk("add_exec_operand_a", alu_operand_a, 5);
        @(posedge clk); #1;
        chk("add_resp_rsp_valid", rsp_valid, 1);
        chk("add_resp_sels", sels, 0);
        drain();

        send(1, 3'd1, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, 1'b1, w);
        drain();
        send(1, 3'd4, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, w);
        drain();

        // Contention: both requesters valid continuously
`ifdef ALU_ARB_ROUND_ROBIN_EN
        exp_ids = '{0, 1, 0, 1};
`else
        exp_ids = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < 4; i++)
            sb.push_back('{id: ID_W'(exp_ids[i]), result: (exp_ids[i] == 0) ? 32'd3 : 32'd6, zero: 1'b0, illegal: 1'b0});
        req_op = {3'd1, 3'd0};
        req_a  = {32'd10, 32'd1};
        req_b  = {32'd4, 32'd2};
        req_valid = 2'b11;
        #1;
        g = 0;
        n = 0;
        while (g < 4 && n < 60) begin
            if (req_ready != '0) begin
                chk($sformatf("contention_grant%0d", g), req_ready, 64'd1 << exp_ids[g]);
                g++;
            end
            @(posedge clk); #1;
            n++;
        end
        req_valid = '0;
        chk("contention_grants_bounded", g, 4);
        drain();

        // Backpressure in RESP with a competing request pending
        rsp_ready = 1'b0;
        send(0, 3'd2, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1'b0, 1'b1, w);
        req_op[5:3]   = 3'd3;
        req_a[63:32]  = 32'h0F;
        req_b[63:32]  = 32'hF0;
        req_valid[1]  = 1'b1;
        @(posedge clk); #1;
        chk("bp_rsp_valid", rsp_valid, 1);
        snap_r  = rsp_result;
        snap_z  = rsp_zero;
        snap_id = rsp_id;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("bp_valid_held", rsp_valid, 1);
            chk("bp_result_stable", rsp_result, snap_r);
            chk("bp_zero_stable", rsp_zero, snap_z);
            chk("bp_id_stable", rsp_id, snap_id);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_sels", sels, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_grant", req_ready, 2'b10);
        sb.push_back('{id: 1'b1, result: 32'hFF, zero: 1'b0, illegal: 1'b0});
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        drain();

        // Illegal opcode
        send(0, 3'd7, 32'd3, 32'd4, 32'd0, 1'b1, 1'b1, 1'b1, w);
        chk("illegal_exec_sels", sels, 0);
        @(posedge clk); #1;
        chk("illegal_resp_sels", sels, 0);
        drain();

        // Reset during EXEC aborts the transaction
        send(0, 3'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, w);
        chk("abort_in_exec", sels, 5'b10000);
        rst_n  = 1'b0;
        req_op = {3'd1, 3'd0};
        req_a  = {32'd10, 32'd20};
        req_b  = {32'd4, 32'd22};
        req_valid = 2'b11;
        @(posedge clk); #1;
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_rsp_result", rsp_result, 0);
        chk("abort_rsp_zero", rsp_zero, 0);
        chk("abort_rsp_illegal", rsp_illegal, 0);
        chk("abort_rsp_id", rsp_id, 0);
        chk("abort_operand_a", alu_operand_a, 0);
        chk("abort_operand_b", alu_operand_b, 0);
        chk("abort_sels", sels, 0);
        chk("abort_req_ready_in_reset", req_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("post_reset_grant", req_ready, 2'b01);
        sb.push_back('{id: 1'b0, result: 32'd42, zero: 1'b0, illegal: 1'b0});
        @(posedge clk); #1;
        req_valid = '0;
        drain();
        repeat (4) @(posedge clk);
        #1;
        chk("final_idle", rsp_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

- Shares the single-cycle combinational ALU among `NUM_REQ` requesters, such as the branch comparator, the address generator and the execute stage.
- Accepts one operation at a time through a valid/ready handshake and arbitrates between competing requesters.
- Registers the operands and drives the ALU's one-hot operation selects, then captures the result and zero flag.
- Returns a tagged response through a second valid/ready handshake. It sits between the requesting units and the ALU instance.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width.
- `NUM_REQ`, 2: number of requesters. Legal range is 2..8.
- `ID_W`, `$clog2(NUM_REQ)`: width of the requester index.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester grant/accept; at most one bit is high.
- `req_op`  in  NUM_REQ*3  packed `alu_op_e` per requester; requester i occupies bits [3i+2:3i].
- `req_a`, `req_b`  in  NUM_REQ*WIDTH  packed operands per requester.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  ID_W  index of the requester that owns the response.
- `rsp_result`  out  WIDTH  captured ALU result.
- `rsp_zero`  out  1  captured ALU zero flag.
- `rsp_illegal`  out  1  request carried an undefined opcode.
- `alu_operand_a`, `alu_operand_b`  out  WIDTH  registered operands to the ALU.
- `alu_sel_add`, `alu_sel_sub`, `alu_sel_and`, `alu_sel_or`, `alu_sel_slt`  out  1 each  one-hot ALU selects.
- `alu_result`  in  WIDTH  ALU result.
- `alu_zero_flag`  in  1  ALU zero flag.

## Operation
- FSM states are IDLE, EXEC and RESP. The reset state is IDLE.
- **IDLE**
  - If any `req_valid` is high, the arbiter picks winner g and `req_ready[g]` goes high combinationally in the same cycle.
  - On that edge the block latches op, a, b and id = g, then goes to EXEC.
  - If no request is valid, it stays in IDLE.
- **EXEC**
  - The select matching the latched op is driven high.
  - At the end of the cycle `alu_result` and `alu_zero_flag` are captured into the response registers, and the FSM goes to RESP.
- **RESP**
  - `rsp_valid` is 1.
  - On `rsp_valid && rsp_ready` the FSM goes to IDLE. No grant is issued in RESP.
  - All response outputs are held stable while `rsp_ready` is low.
- **Op encoding** (package enum): ADD=0, SUB=1, AND=2, OR=3, SLT=4.
- **Illegal opcodes 5–7**
  - All selects stay low in EXEC, so the ALU outputs 0.
  - The response is `rsp_result`=0, `rsp_zero`=1, `rsp_illegal`=1.
- **Arithmetic**
  - ADD and SUB wrap modulo 2^WIDTH.
  - SLT is an unsigned compare with a 0/1 result, zero-extended.
- **Selects outside EXEC** are all 0. Operand outputs hold the last latched values.
- **Arbitration:** exactly one grant per accepted request. A requester whose `req_valid` drops before it is granted loses nothing.

## Timing
- Request accepted at edge T → `rsp_valid` high from T+2. Peak throughput is one operation per 3 cycles with `rsp_ready` held high.
- Reset values:
  - FSM = IDLE.
  - `req_ready` = 0 (forced to 0 while `rst_n` is low).
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_result` = 0, `rsp_zero` = 0, `rsp_illegal` = 0.
  - `alu_operand_a` = 0, `alu_operand_b` = 0.
  - All selects = 0.
  - Priority pointer = NUM_REQ-1.
- Reset in EXEC or RESP aborts the transaction. `rsp_valid` is 0 from the next cycle and the aborted request never responds.
- A request that arrives while the FSM is in EXEC or RESP waits. `req_ready` stays 0 until the FSM is back in IDLE.

## Configuration
- Macro: `ALU_ARB_ROUND_ROBIN_EN`.
- **Defined:** round-robin arbitration.
  - The search starts at pointer+1 modulo NUM_REQ.
  - The pointer loads g only on a grant.
  - Under continuous contention, grants rotate 0,1,…,NUM_REQ-1.
- **Undefined:** fixed priority. The lowest valid index always wins, and the pointer register is not built.

## Structure
- Package `alu_ctrl_pkg` holds:
  - `alu_op_e` (3-bit) with the encodings above.
  - `arb_state_e` (IDLE/EXEC/RESP).
  - The `ALU_OP_W = 3` constant.
- Sub-module `rr_arbiter`, parameterised on `NUM_REQ`:
  - Inputs: request vector, enable, pointer.
  - Outputs: one-hot grant and the encoded index.
  - It honours `ALU_ARB_ROUND_ROBIN_EN`.
- The top level contains the FSM, the operand, response and pointer registers, and the op-to-select decode.

## Test plan
- **Single ADD:** req0 ADD 5+7 → `req_ready[0]` high in the same cycle; at T+2 `rsp_valid`=1, `rsp_result`=12, `rsp_zero`=0, `rsp_id`=0.
- **SUB to zero:** req1 SUB 9−9 → `rsp_result`=0, `rsp_zero`=1, `rsp_id`=1. SLT 1 vs 0xFFFFFFFF → `rsp_result`=1.
- **Contention:** both requesters valid continuously with `rsp_ready`=1 → with the macro, grant ids are 0,1,0,1; without it, 0,0,0,0.
- **Backpressure:** `rsp_ready` low for 4 cycles in RESP → `rsp_*` stable, `req_ready` all 0, selects all 0; the handshake on cycle 5 returns the FSM to IDLE.
- **Illegal op:** opcode 7 with a=3, b=4 → selects never asserted; response is `rsp_illegal`=1, `rsp_result`=0, `rsp_zero`=1.
- **Reset mid-operation:** `rst_n` low during EXEC → next cycle `rsp_valid`=0 and all outputs at reset values. No stale response appears, and the next grant goes to req0.
